// File: rtl/div_pkg.sv
// div_pkg: default operand width and 3-bit FSM state encoding shared by the signed divider files
package div_pkg;
  localparam int DEF_WIDTH = 16;
  localparam logic [2:0] IDLE = 3'd0, PRE_CALC = 3'd1, ITERATE = 3'd2, FIX_SIGN = 3'd3, DONE = 3'd4;
endpackage

// File: rtl/signed_divider_if.sv
// signed_divider_if: start/done divide bus (start, 2W dividend, W divisor in; quotient, remainder, done, div_by_zero, overflow out)
interface signed_divider_if import div_pkg::*; #(parameter int WIDTH = DEF_WIDTH) ();
  logic start;
  logic [2*WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor, quotient, remainder;
  logic done, div_by_zero, overflow;
  modport master (output start, dividend, divisor, input quotient, remainder, done, div_by_zero, overflow);
  modport slave (input start, dividend, divisor, output quotient, remainder, done, div_by_zero, overflow);
endinterface

// File: rtl/div_step.sv
// div_step: one restoring step; ports rem_i, in_bit_i, divisor_i -> next_rem_o, q_bit_o
module div_step #(parameter int WIDTH = 16) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             in_bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] next_rem_o,
  output logic             q_bit_o
);
  logic [WIDTH:0] trial;
  assign trial = {rem_i, in_bit_i} - {1'b0, divisor_i};
  assign q_bit_o = ~trial[WIDTH];
  assign next_rem_o = q_bit_o ? trial[WIDTH-1:0] : {rem_i[WIDTH-2:0], in_bit_i};
endmodule

// File: rtl/signed_divider.sv
// signed_divider: restoring signed 2W/W divider, one quotient bit per clock; ports clk_i, rst_i (async high), bus (slave)
module signed_divider import div_pkg::*; #(parameter int WIDTH = DEF_WIDTH) (
  input logic clk_i,
  input logic rst_i,
  signed_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  logic [2:0] state_q, state_d;
  logic [2*WIDTH-1:0] dvd_q, dvd_d, ad;
  logic [WIDTH-1:0] dvs_q, dvs_d, adv, adv_q, adv_d, rem_q, rem_d, sh_q, sh_d;
  logic [WIDTH-1:0] quo_q, quo_d, rmd_q, rmd_d, nrem;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sq_q, sq_d, sr_q, sr_d, dz_q, dz_d, ov_q, ov_d;
  logic dzo_q, dzo_d, ovo_q, ovo_d, done_q, done_d;
  logic pz, po, qb, rov, bad;
  assign ad = dvd_q[2*WIDTH-1] ? -dvd_q : dvd_q;
  assign adv = dvs_q[WIDTH-1] ? -dvs_q : dvs_q;
  assign pz = dvs_q == '0;
  assign po = ad[2*WIDTH-1:WIDTH] >= adv;
  assign rov = sq_q ? sh_q > {1'b1, {(WIDTH-1){1'b0}}} : sh_q[WIDTH-1];
  assign bad = dz_q | ov_q | rov;
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i(rem_q), .in_bit_i(sh_q[WIDTH-1]), .divisor_i(adv_q), .next_rem_o(nrem), .q_bit_o(qb)
  );
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= IDLE;
      dvd_q <= '0;
      dvs_q <= '0;
      adv_q <= '0;
      rem_q <= '0;
      sh_q <= '0;
      cnt_q <= '0;
      {sq_q, sr_q, dz_q, ov_q} <= '0;
      quo_q <= '0;
      rmd_q <= '0;
      {dzo_q, ovo_q, done_q} <= '0;
    end else begin
      state_q <= state_d;
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      adv_q <= adv_d;
      rem_q <= rem_d;
      sh_q <= sh_d;
      cnt_q <= cnt_d;
      {sq_q, sr_q, dz_q, ov_q} <= {sq_d, sr_d, dz_d, ov_d};
      quo_q <= quo_d;
      rmd_q <= rmd_d;
      {dzo_q, ovo_q, done_q} <= {dzo_d, ovo_d, done_d};
    end
  always_comb
    state_d = state_q == IDLE     ? (bus.start ? PRE_CALC : IDLE) :
              state_q == PRE_CALC ? (pz || po ? FIX_SIGN : ITERATE) :
              state_q == ITERATE  ? (cnt_q == CW'(WIDTH-1) ? FIX_SIGN : ITERATE) :
              state_q == FIX_SIGN ? DONE :
              state_q == DONE     ? (bus.start ? DONE : IDLE) : IDLE;
  always_comb begin
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    adv_d = adv_q;
    rem_d = rem_q;
    sh_d = sh_q;
    cnt_d = cnt_q;
    {sq_d, sr_d, dz_d, ov_d} = {sq_q, sr_q, dz_q, ov_q};
    quo_d = quo_q;
    rmd_d = rmd_q;
    {dzo_d, ovo_d} = {dzo_q, ovo_q};
    if (state_q == IDLE && bus.start) begin
      dvd_d = bus.dividend;
      dvs_d = bus.divisor;
    end
    if (state_q == PRE_CALC) begin
      adv_d = adv;
      sq_d = dvd_q[2*WIDTH-1] ^ dvs_q[WIDTH-1];
      sr_d = dvd_q[2*WIDTH-1];
      dz_d = pz;
      ov_d = !pz && po;
      rem_d = ad[2*WIDTH-1:WIDTH];
      sh_d = ad[WIDTH-1:0];
      cnt_d = '0;
    end
    if (state_q == ITERATE) begin
      rem_d = nrem;
      sh_d = {sh_q[WIDTH-2:0], qb};
      cnt_d = cnt_q + 1'b1;
    end
    if (state_q == FIX_SIGN) begin
      quo_d = bad ? '0 : sq_q ? -sh_q : sh_q;
      rmd_d = bad ? '0 : sr_q ? -rem_q : rem_q;
      dzo_d = dz_q;
      ovo_d = ov_q | (!dz_q && rov);
    end
  end
  assign done_d = state_d == DONE;
  assign bus.quotient = quo_q;
  assign bus.remainder = rmd_q;
  assign bus.div_by_zero = dzo_q;
  assign bus.overflow = ovo_q;
  assign bus.done = done_q;
endmodule
